// File: rtl/fpu_pkg.sv
// Shared types for the COP1 issue controller: request kinds, ALU op codes,
// controller states and the latched ALU request bundle.
package fpu_pkg;

    localparam int REG_AW = 5;
    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        FOP_ADD = 3'd0,
        FOP_SUB = 3'd1
    } fop_e;

    typedef enum logic [1:0] {
        K_ALU  = 2'd0,
        K_MTC1 = 2'd1,
        K_MFC1 = 2'd2,
        K_RSVD = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0]        op;
        logic [REG_AW-1:0] fs;
        logic [REG_AW-1:0] ft;
        logic [REG_AW-1:0] fd;
    } alu_req_t;

endpackage

// File: rtl/fpu_regfile.sv
// FP register file: two asynchronous read ports, one synchronous write port,
// whole array cleared by the asynchronous reset.
module fpu_regfile
    import fpu_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     raddr1,
    output logic [WORD_W-1:0] rdata1,
    input  logic [AW-1:0]     raddr2,
    output logic [WORD_W-1:0] rdata2,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata
);

    logic [WORD_W-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// COP1 issue controller: accepts one request at a time, reads operands,
// drives coprocessor1 for EXEC_CYCLES, writes back and returns a response.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int NREGS       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_kind,
    input  logic [2:0]        req_op,
    input  logic [REG_AW-1:0] req_fs,
    input  logic [REG_AW-1:0] req_ft,
    input  logic [REG_AW-1:0] req_fd,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_data,
    output logic [WORD_W-1:0] data1,
    output logic [WORD_W-1:0] data2,
    output logic [2:0]        FloatALUop,
    input  logic [WORD_W-1:0] floatRes
);

    localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

    state_e            state;
    state_e            state_nxt;
    alu_req_t          areq;
    kind_e             kind;
    logic [CW-1:0]     cnt;
    logic [REG_AW-1:0] raddr1;
    logic [WORD_W-1:0] rdata1;
    logic [WORD_W-1:0] rdata2;
    logic              we;
    logic [REG_AW-1:0] waddr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] resp_nxt;

    assign kind       = kind_e'(req_kind);
    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_WB);

    // MFC1 reads in IDLE straight from the request; ALU reads in READ.
    assign raddr1 = (state == S_IDLE) ? req_fs : areq.fs;

    fpu_regfile #(
        .NREGS (NREGS),
        .AW    (REG_AW)
    ) u_regs (
        .clk    (clk),
        .reset  (reset),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (areq.ft),
        .rdata2 (rdata2),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata)
    );

    // The register write is tied to the transition into WB, so it
    // happens exactly once no matter how long WB stalls.
    always_comb begin
        state_nxt = state;
        we        = 1'b0;
        waddr     = areq.fd;
        wdata     = floatRes;
        resp_nxt  = resp_data;
        unique case (state)
            S_IDLE: begin
                if (req_valid) begin
                    unique case (kind)
                        K_ALU: begin
                            state_nxt = S_READ;
                        end
                        K_MTC1: begin
                            state_nxt = S_WB;
                            we        = 1'b1;
                            waddr     = req_fd;
                            wdata     = req_wdata;
                            resp_nxt  = req_wdata;
                        end
                        K_MFC1: begin
                            state_nxt = S_WB;
                            resp_nxt  = rdata1;
                        end
                        default: begin
                            state_nxt = S_WB;
                            resp_nxt  = '0;
                        end
                    endcase
                end
            end
            S_READ: begin
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (cnt == '0) begin
                    state_nxt = S_WB;
                    we        = 1'b1;
                    resp_nxt  = floatRes;
                end
            end
            S_WB: begin
                if (resp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            areq <= '0;
        end else if (state == S_IDLE && req_valid && kind == K_ALU) begin
            areq <= '{op: req_op, fs: req_fs, ft: req_ft, fd: req_fd};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state == S_READ) begin
            cnt <= CW'(EXEC_CYCLES - 1);
        end else if (state == S_EXEC && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Operand bus only moves in READ so coprocessor1 inputs never toggle
    // outside an operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data1      <= '0;
            data2      <= '0;
            FloatALUop <= '0;
        end else if (state == S_READ) begin
            data1      <= rdata1;
            data2      <= rdata2;
            FloatALUop <= areq.op;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_data <= '0;
        end else begin
            resp_data <= resp_nxt;
        end
    end

endmodule
